mul_exp_requester: RTL

//  Initiator for the serial multiplier I/O handshake: drives p1/p2/P/drdy_i and consumes drdy_o/out.

---
 rtl/mul_exp_requester_pkg.sv | 23 ++
 rtl/mul_exp_requester_if.sv | 22 ++
 rtl/mul_exp_requester_port.sv | 79 +++++++
 rtl/mul_exp_requester.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mul_exp_requester_pkg.sv
// Shared types for the exponentiation requester: field/share encoding, FSM states and the identity.
package mul_exp_requester_pkg;

    localparam int unsigned D       = 1;
    localparam int unsigned FIELD_W = 8;

    typedef logic [FIELD_W-1:0] share_t;
    typedef share_t [D-1:0]     state_t;
    typedef logic [FIELD_W:0]   base_poly_t;

    typedef enum logic [2:0] {
        REQ_IDLE,
        REQ_SQ_REQ,
        REQ_SQ_WAIT,
        REQ_ML_REQ,
        REQ_ML_WAIT,
        REQ_FIN
    } req_state_e;

    // Field identity: 1 in share 0, zero in every other share.
    localparam state_t ONE = state_t'(1);

endpackage

// File: rtl/mul_exp_requester_if.sv
// Operand/strobe bundle between the requester and one serial multiplier.
interface mul_exp_requester_if;
    import mul_exp_requester_pkg::*;

    state_t     mul_p1;
    state_t     mul_p2;
    base_poly_t mul_P;
    logic       mul_drdy_i;
    logic       mul_drdy_o;
    state_t     mul_out;

    modport master (
        output mul_p1, mul_p2, mul_P, mul_drdy_i,
        input  mul_drdy_o, mul_out
    );

    modport slave (
        input  mul_p1, mul_p2, mul_P, mul_drdy_i,
        output mul_drdy_o, mul_out
    );

endinterface

// File: rtl/mul_exp_requester_port.sv
// Multiplier request port: operand registers, one-cycle request strobe and response watchdog.
module mul_req_port
    import mul_exp_requester_pkg::*;
#(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       p_load_i,
    input  base_poly_t                 p_i,
    input  logic                       issue_sq_i,
    input  logic                       issue_ml_i,
    input  state_t                     acc_i,
    input  state_t                     base_i,
    input  logic                       waiting_i,
    output logic                       resp_o,
    output logic                       timeout_o,
    mul_exp_requester_if.master        mul
);

    localparam int unsigned WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t          p1_q, p1_d;
    state_t          p2_q, p2_d;
    base_poly_t      P_q, P_d;
    logic            drdy_q, drdy_d;
    logic [WD_W-1:0] wdog_q, wdog_d;

    always_comb begin
        p1_d   = p1_q;
        p2_d   = p2_q;
        P_d    = P_q;
        drdy_d = 1'b0;
        wdog_d = wdog_q;
        if (p_load_i) begin
            P_d = p_i;
        end
        if (issue_sq_i) begin
            p1_d   = acc_i;
            p2_d   = acc_i;
            drdy_d = 1'b1;
            wdog_d = '0;
        end else if (issue_ml_i) begin
            p1_d   = acc_i;
            p2_d   = base_i;
            drdy_d = 1'b1;
            wdog_d = '0;
        end else if (TIMEOUT != 0 && waiting_i && !mul.mul_drdy_o) begin
            wdog_d = wdog_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_q   <= '0;
            p2_q   <= '0;
            P_q    <= '0;
            drdy_q <= 1'b0;
            wdog_q <= '0;
        end else begin
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            P_q    <= P_d;
            drdy_q <= drdy_d;
            wdog_q <= wdog_d;
        end
    end

    assign resp_o = waiting_i & mul.mul_drdy_o;
    // Fires in the TIMEOUT-th unanswered WAIT cycle; a response in that same cycle still wins.
    assign timeout_o = (TIMEOUT != 0) && waiting_i && !mul.mul_drdy_o
                       && (wdog_q == WD_W'(TIMEOUT - 1));

    assign mul.mul_p1     = p1_q;
    assign mul.mul_p2     = p2_q;
    assign mul.mul_P      = P_q;
    assign mul.mul_drdy_i = drdy_q;

endmodule

// File: rtl/mul_exp_requester.sv
// MSB-first square-and-multiply exponentiation driving one external field multiplier.
module mul_exp_requester
    import mul_exp_requester_pkg::*;
#(
    parameter int unsigned d       = D,
    parameter int unsigned E_W     = 8,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  state_t              base_i,
    input  logic [E_W-1:0]      exp_i,
    input  base_poly_t          P_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output state_t              result_o,
    mul_exp_requester_if.master mul
);

    localparam int unsigned BIT_W = (E_W < 2) ? 1 : $clog2(E_W);

    if (d != D) begin : g_bad_d
        $error("mul_exp_requester: d must equal the package share count D");
    end

    req_state_e       state_q, state_d;
    state_t           acc_q, acc_d;
    state_t           base_q, base_d;
    state_t           result_q, result_d;
    logic [E_W-1:0]   exp_q, exp_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             done_q, done_d;
    logic             issue_sq, issue_ml, p_load;
    logic             waiting, resp, timeout;

    assign waiting = (state_q == REQ_SQ_WAIT) || (state_q == REQ_ML_WAIT);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        base_d   = base_q;
        exp_d    = exp_q;
        bit_d    = bit_q;
        result_d = result_q;
        done_d   = 1'b0;
        issue_sq = 1'b0;
        issue_ml = 1'b0;
        p_load   = 1'b0;
        unique case (state_q)
            REQ_IDLE: begin
                if (start_i) begin
                    base_d = base_i;
                    exp_d  = exp_i;
                    acc_d  = ONE;
                    bit_d  = BIT_W'(E_W - 1);
                    p_load = 1'b1;
                    if (exp_i == '0) begin
                        state_d = REQ_FIN;
                    end else begin
                        state_d  = REQ_SQ_REQ;
                        issue_sq = 1'b1;
                    end
                end
            end
            REQ_SQ_REQ: state_d = REQ_SQ_WAIT;
            REQ_SQ_WAIT: begin
                if (resp) begin
                    acc_d = mul.mul_out;
                    if (exp_q[bit_q]) begin
                        state_d  = REQ_ML_REQ;
                        issue_ml = 1'b1;
                    end else if (bit_q == '0) begin
                        state_d = REQ_FIN;
                    end else begin
                        bit_d    = bit_q - 1'b1;
                        state_d  = REQ_SQ_REQ;
                        issue_sq = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = REQ_IDLE;
                end
            end
            REQ_ML_REQ: state_d = REQ_ML_WAIT;
            REQ_ML_WAIT: begin
                if (resp) begin
                    acc_d = mul.mul_out;
                    if (bit_q == '0) begin
                        state_d = REQ_FIN;
                    end else begin
                        bit_d    = bit_q - 1'b1;
                        state_d  = REQ_SQ_REQ;
                        issue_sq = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = REQ_IDLE;
                end
            end
            REQ_FIN: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = REQ_IDLE;
            end
            default: state_d = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= REQ_IDLE;
            acc_q    <= '0;
            base_q   <= '0;
            exp_q    <= '0;
            bit_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            base_q   <= base_d;
            exp_q    <= exp_d;
            bit_q    <= bit_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Operands for the next request come from acc_d so they match the value acc is about to take.
    mul_req_port #(
        .TIMEOUT (TIMEOUT)
    ) u_port (
        .clk        (clk),
        .rst        (rst),
        .p_load_i   (p_load),
        .p_i        (P_i),
        .issue_sq_i (issue_sq),
        .issue_ml_i (issue_ml),
        .acc_i      (acc_d),
        .base_i     (base_q),
        .waiting_i  (waiting),
        .resp_o     (resp),
        .timeout_o  (timeout),
        .mul        (mul)
    );

    assign busy_o   = (state_q != REQ_IDLE);
    assign done_o   = done_q;
    assign err_o    = timeout;
    assign result_o = result_q;

endmodule
